// File: rtl/flag_branch_unit.sv
// -----------------------------------------------------------------------------
// flag_branch_unit
//
// Holds the architectural Z/N/V condition flags and the EX/MEM pipeline
// register. It also resolves the branch condition for the instruction in ID.
// The flag values that the EX instruction is about to write are forwarded
// straight into the branch comparator. A flag-setting instruction in EX can
// therefore be followed immediately by a dependent branch in ID, with no
// stall cycle.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   ex_valid           EX stage holds a real instruction
//   Opcode[3:0]        EX-stage opcode
//   ALU_Out[15:0]      ALU result (passed through unmodified to MEM)
//   Ovfl, Neg, Zero    raw ALU flags
//   Flag_Write         ALU requests a flag update
//   stall              hold the EX/MEM stage
//   flush              squash the EX instruction
//   br_valid           ID stage holds B or BR
//   br_ccc[2:0]        branch condition code
//   Z_q, N_q, V_q      architectural flags
//   br_taken           branch condition satisfied (combinational)
//   mem_valid          EX/MEM register valid
//   mem_opcode[3:0]    EX/MEM opcode
//   mem_result[15:0]   EX/MEM ALU result
// -----------------------------------------------------------------------------
module flag_branch_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  Opcode,
  input  logic [15:0] ALU_Out,
  input  logic        Ovfl,
  input  logic        Neg,
  input  logic        Zero,
  input  logic        Flag_Write,
  input  logic        stall,
  input  logic        flush,
  input  logic        br_valid,
  input  logic [2:0]  br_ccc,
  output logic        Z_q,
  output logic        N_q,
  output logic        V_q,
  output logic        br_taken,
  output logic        mem_valid,
  output logic [3:0]  mem_opcode,
  output logic [15:0] mem_result
);

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_XOR = 4'h2;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRA = 4'h5;
  localparam logic [3:0] OP_ROR = 4'h6;

  localparam logic [2:0] CC_NE = 3'b000;
  localparam logic [2:0] CC_EQ = 3'b001;
  localparam logic [2:0] CC_GT = 3'b010;
  localparam logic [2:0] CC_LT = 3'b011;
  localparam logic [2:0] CC_GE = 3'b100;
  localparam logic [2:0] CC_LE = 3'b101;
  localparam logic [2:0] CC_OV = 3'b110;
  localparam logic [2:0] CC_UN = 3'b111;

  logic        ex_commit;
  logic        Z_d;
  logic        N_d;
  logic        V_d;
  logic        mem_valid_q;
  logic        mem_valid_d;
  logic [3:0]  mem_opcode_q;
  logic [3:0]  mem_opcode_d;
  logic [15:0] mem_result_q;
  logic [15:0] mem_result_d;

  assign ex_commit = ex_valid & ~stall & ~flush;

  // Next flag values. These are also the effective flags seen by the branch
  // comparator, which gives EX->ID forwarding for free.
  always_comb begin
    Z_d = Z_q;
    N_d = N_q;
    V_d = V_q;
    if (ex_commit && Flag_Write) begin
      case (Opcode)
        OP_ADD, OP_SUB: begin
          Z_d = Zero;
          N_d = Neg;
          V_d = Ovfl;
        end
        OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
          Z_d = Zero;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    br_taken = 1'b0;
    if (br_valid) begin
      case (br_ccc)
        CC_NE:   br_taken = ~Z_d;
        CC_EQ:   br_taken = Z_d;
        CC_GT:   br_taken = ~Z_d & ~N_d;
        CC_LT:   br_taken = N_d;
        CC_GE:   br_taken = Z_d | ~N_d;
        CC_LE:   br_taken = N_d | Z_d;
        CC_OV:   br_taken = V_d;
        CC_UN:   br_taken = 1'b1;
        default: br_taken = 1'b0;
      endcase
    end
  end

  // EX/MEM register: flush beats stall, stall beats load.
  always_comb begin
    mem_valid_d  = mem_valid_q;
    mem_opcode_d = mem_opcode_q;
    mem_result_d = mem_result_q;
    if (flush) begin
      mem_valid_d  = 1'b0;
      mem_opcode_d = 4'h0;
      mem_result_d = 16'h0000;
    end else if (!stall) begin
      mem_valid_d  = ex_valid;
      mem_opcode_d = Opcode;
      mem_result_d = ALU_Out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Z_q          <= 1'b0;
      N_q          <= 1'b0;
      V_q          <= 1'b0;
      mem_valid_q  <= 1'b0;
      mem_opcode_q <= 4'h0;
      mem_result_q <= 16'h0000;
    end else begin
      Z_q          <= Z_d;
      N_q          <= N_d;
      V_q          <= V_d;
      mem_valid_q  <= mem_valid_d;
      mem_opcode_q <= mem_opcode_d;
      mem_result_q <= mem_result_d;
    end
  end

  assign mem_valid  = mem_valid_q;
  assign mem_opcode = mem_opcode_q;
  assign mem_result = mem_result_q;

endmodule
